// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flags family.
// Provides the read-mode encodings, a constant clog2 and the default almost-full threshold.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Two below full, but never below 1 so tiny FIFOs still get a legal threshold.
    function automatic int default_afull(input int depth);
        return (depth > 2) ? depth - 2 : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for sync_fifo_flags.
// Synchronous write port and asynchronous read port; contents are never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int addr_width = clog2(depth)
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [addr_width-1:0] w_addr,
    input  logic [data_width-1:0] w_data,
    input  logic [addr_width-1:0] r_addr,
    output logic [data_width-1:0] r_data
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// overflow/underflow pulses and selectable registered or first-word-fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int depth         = 8,
    parameter int afull_thresh  = default_afull(depth),
    parameter int aempty_thresh = 1,
    parameter int fwft          = FIFO_MODE_STD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [data_width-1:0]   data_in,
    output logic [data_width-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(depth):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = clog2(depth);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C  = PW'(depth);
    localparam logic [PW-1:0] AFULL_C  = PW'(afull_thresh);
    localparam logic [PW-1:0] AEMPTY_C = PW'(aempty_thresh);

    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_flags: depth=%0d must be a power of two >= 2", depth);
    end
    if (afull_thresh < 1 || afull_thresh > depth) begin : g_bad_afull
        $fatal(1, "sync_fifo_flags: afull_thresh=%0d outside 1..%0d", afull_thresh, depth);
    end
    if (aempty_thresh < 0 || aempty_thresh > depth - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo_flags: aempty_thresh=%0d outside 0..%0d", aempty_thresh, depth - 1);
    end
    if (fwft != FIFO_MODE_STD && fwft != FIFO_MODE_FWFT) begin : g_bad_mode
        $fatal(1, "sync_fifo_flags: fwft=%0d is not a valid read mode", fwft);
    end

    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic                  w_acc;
    logic                  r_acc;
    logic [data_width-1:0] rd_data;

    // Flags come only from the registered count, so inputs never reach them combinationally.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign w_acc = w_en & ~full;
    assign r_acc = r_en & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_acc) begin
                w_ptr <= w_ptr + PW'(1);
            end
            if (r_acc) begin
                r_ptr <= r_ptr + PW'(1);
            end
            case ({w_acc, r_acc})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            overflow  <= w_en & full;
            underflow <= r_en & empty;
        end
    end

    fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (AW)
    ) u_mem (
        .clk    (clk),
        .w_en   (w_acc),
        .w_addr (w_ptr[AW-1:0]),
        .w_data (data_in),
        .r_addr (r_ptr[AW-1:0]),
        .r_data (rd_data)
    );

    if (fwft == FIFO_MODE_FWFT) begin : g_fwft
        assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_out <= '0;
            end else if (r_acc) begin
                data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: registered-read and FWFT instances share stimulus,
// a queue-based reference model predicts every post-edge output and a monitor compares.
module tb_sync_fifo_flags;

    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en;
    logic       r_en;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [3:0] s_cnt, f_cnt;

    always #5 clk = ~clk;

    sync_fifo_flags #(.data_width(8), .depth(DEPTH), .fwft(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_cnt), .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_flags #(.data_width(8), .depth(DEPTH), .fwft(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt), .overflow(f_ov), .underflow(f_un)
    );

    typedef struct {
        int         cnt;
        logic       ov;
        logic       un;
        logic [7:0] d_std;
        logic [7:0] d_fwft;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [7:0] mq[$];
    logic [7:0] m_dstd;
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic check_all(input int cnt, input logic ov, input logic un,
                             input logic [7:0] dstd, input logic [7:0] dfwft);
        logic ef, ee, eaf, eae;
        ef  = (cnt == DEPTH);
        ee  = (cnt == 0);
        eaf = (cnt >= AFULL);
        eae = (cnt <= AEMPTY);
        chk("std_count", 32'(s_cnt), 32'(cnt));
        chk("std_full", 32'(s_full), 32'(ef));
        chk("std_empty", 32'(s_empty), 32'(ee));
        chk("std_almost_full", 32'(s_af), 32'(eaf));
        chk("std_almost_empty", 32'(s_ae), 32'(eae));
        chk("std_overflow", 32'(s_ov), 32'(ov));
        chk("std_underflow", 32'(s_un), 32'(un));
        chk("std_data_out", 32'(s_dout), 32'(dstd));
        chk("fwft_count", 32'(f_cnt), 32'(cnt));
        chk("fwft_full", 32'(f_full), 32'(ef));
        chk("fwft_empty", 32'(f_empty), 32'(ee));
        chk("fwft_almost_full", 32'(f_af), 32'(eaf));
        chk("fwft_almost_empty", 32'(f_ae), 32'(eae));
        chk("fwft_overflow", 32'(f_ov), 32'(ov));
        chk("fwft_underflow", 32'(f_un), 32'(un));
        chk("fwft_data_out", 32'(f_dout), 32'(dfwft));
    endtask

    // Monitor: the front record always describes the edge that has just occurred.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_all(cur.cnt, cur.ov, cur.un, cur.d_std, cur.d_fwft);
        end
    end

    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        exp_t e;
        bit   was_full, was_empty;
        @(negedge clk);
        w_en    = w;
        r_en    = r;
        data_in = d;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        e.ov = w && was_full;
        e.un = r && was_empty;
        if (r && !was_empty) m_dstd = mq.pop_front();
        if (w && !was_full)  mq.push_back(d);
        e.cnt    = mq.size();
        e.d_std  = m_dstd;
        e.d_fwft = (mq.size() > 0) ? mq[0] : 8'h00;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_dstd = 8'h00;
    endtask

    initial begin
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);

        // Fill A0..A7, one rejected write, then idle so the overflow pulse ends.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'hA0 + 8'(i));
        cycle(1, 0, 8'hEE);
        cycle(0, 0, 8'h00);

        // Drain in order, one rejected read, idle.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Steady state at count=4 with concurrent read/write; pointers wrap twice.
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'($urandom));
        for (int i = 0; i < 20; i++) cycle(1, 1, 8'($urandom));
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // FWFT focus: word shows without r_en, pop, then simultaneous access on empty.
        cycle(1, 0, 8'h5C);
        cycle(0, 0, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);
        cycle(1, 1, 8'h33);
        cycle(0, 0, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Asynchronous reset in the middle of a cycle at count=5.
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'h10 + 8'(i));
        #3;
        w_en = 1'b0; r_en = 1'b0;
        rst  = 1'b0;
        model_reset();
        #1;
        check_all(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 0, 8'h77);
        cycle(0, 0, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Random traffic with near-full/near-empty excursions.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        cycle(0, 0, 8'h00);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
